wm8960_ctrl_responder: RTL and testbench

I2C target model of the WM8960 control port. It is the receiving end of the codec initialisation path. It oversamples SCL/SDA on the system clock, decodes START/STOP, and checks the device address. It ACKs each byte, assembles each two-byte frame {7-bit register, 9-bit data} and writes it into a shadow register file. Used in the audio loopback benches to check that the init sequencer and I2C master deliver the full register list, and as a register-file stand-in on boards without a codec.

---
 rtl/wm8960_pkg.sv | 35 +++
 rtl/wm8960_ctrl_responder_filter.sv | 56 +++++
 rtl/wm8960_ctrl_responder.sv | 173 +++++++++++++++++
 tb/tb_wm8960_ctrl_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8960_pkg.sv
// Shared constants, FSM state type and small helpers for the WM8960 control-port responder.
package wm8960_pkg;

  localparam logic [7:0] WM8960_DEV_ADDR  = 8'h34;
  localparam logic [6:0] WM8960_REG_RESET = 7'h0F;
  localparam int         WM8960_REG_NUM   = 56;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_ACK_D     = 4'd2,
    ST_BYTE1     = 4'd3,
    ST_ACK_1     = 4'd4,
    ST_BYTE2     = 4'd5,
    ST_ACK_2     = 4'd6,
    ST_WAIT_STOP = 4'd7,
    ST_IGNORE    = 4'd8
  } wm8960_state_e;

  // 9-bit register data: bit 8 travels as the LSB of the first byte.
  function automatic logic [8:0] frame_data(input logic [7:0] byte1, input logic [7:0] byte2);
    return {byte1[0], byte2};
  endfunction

  // State that follows the end of each ACK clock.
  function automatic wm8960_state_e ack_next(input wm8960_state_e s);
    case (s)
      ST_ACK_D: return ST_BYTE1;
      ST_ACK_1: return ST_BYTE2;
      ST_ACK_2: return ST_WAIT_STOP;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wm8960_ctrl_responder_filter.sv
// Line conditioner: 2-flop synchroniser, FILTER_LEN-sample glitch filter, edge flags.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FILTER_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronise, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt  <= '0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else if (r_cnt == LAST_CNT) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/wm8960_ctrl_responder.sv
// I2C write-only target modelling the WM8960 control port with a 9-bit shadow register file.
module wm8960_ctrl_responder
  import wm8960_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR   = WM8960_DEV_ADDR,
  parameter int         REG_NUM    = WM8960_REG_NUM,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);

  localparam int         AW        = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [7:0] REG_LIMIT = 8'(REG_NUM);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .reset(reset), .i_line(scl_i),
    .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .reset(reset), .i_line(sda_i),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  wm8960_state_e r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte1;
  logic          r_sda_oe;
  logic          r_wr_valid;
  logic [6:0]    r_wr_addr;
  logic [8:0]    r_wr_data;
  logic          r_busy;
  logic [8:0]    r_regs [REG_NUM];

  logic       w_start, w_stop, w_commit, w_in_range;
  logic [7:0] w_byte;
  logic [6:0] w_commit_addr;
  logic [8:0] w_commit_data;
  logic [8:0] w_rd_data;

  // Bus conditions and the frame commit strobe, derived from the filtered lines.
  always_comb begin
    w_start       = w_sda_fall & w_scl_lvl;
    w_stop        = w_sda_rise & w_scl_lvl;
    w_byte        = {r_shift[6:0], w_sda_lvl};
    w_commit      = (r_state == ST_BYTE2) & w_scl_rise & (r_bit_cnt == 3'd7) & ~w_start & ~w_stop;
    w_commit_addr = r_byte1[7:1];
    w_commit_data = frame_data(r_byte1, w_byte);
    w_in_range    = ({1'b0, w_commit_addr} < REG_LIMIT);
  end

  // Protocol FSM: START/STOP handling, bit shifting, ACK drive and commit outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_byte1    <= 8'd0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 7'd0;
      r_wr_data  <= 9'd0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_DEV;
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          ST_DEV: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                // R/W=1 also fails this compare since DEV_ADDR is the write form.
                r_state <= (w_byte == DEV_ADDR) ? ST_ACK_D : ST_IGNORE;
              end
            end
          end
          ST_BYTE1: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte1 <= w_byte;
                r_state <= ST_ACK_1;
              end
            end
          end
          ST_BYTE2: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_commit) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= w_commit_addr;
                r_wr_data  <= w_commit_data;
                r_state    <= ST_ACK_2;
              end
            end
          end
          ST_ACK_D, ST_ACK_1, ST_ACK_2: begin
            // First SCL fall starts the ACK, the next one ends it.
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= ack_next(r_state);
              end
            end
          end
          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Shadow register file: single write port, cleared by reset or the software-reset register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= 9'd0;
    end else if (w_commit && (w_commit_addr == WM8960_REG_RESET)) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= 9'd0;
    end else if (w_commit && w_in_range) begin
      r_regs[w_commit_addr[AW-1:0]] <= w_commit_data;
    end
  end

  // Zero-latency debug read; addresses beyond the file read as zero.
  always_comb begin
    w_rd_data = 9'd0;
    if ({1'b0, rd_addr} < REG_LIMIT) begin
      w_rd_data = r_regs[rd_addr[AW-1:0]];
    end else begin
      w_rd_data = 9'd0;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_data  = w_rd_data;
  assign busy     = r_busy;

endmodule

// File: tb/tb_wm8960_ctrl_responder.sv
// Directed bench: a bit-banged I2C master drives frames into the responder.
module tb_wm8960_ctrl_responder;

  localparam int Q = 12;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [6:0] rd_addr = 7'd0;
  logic [8:0] rd_data;

  int         checks = 0;
  int         failures = 0;
  int         n_wr = 0;
  logic       oe_seen = 1'b0;
  logic [6:0] last_addr = 7'd0;
  logic [8:0] last_data = 9'd0;

  assign sda_bus = sda_m & ~sda_oe;

  wm8960_ctrl_responder dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Commit and ACK monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_valid) begin
      n_wr = n_wr + 1;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input bit glitch);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q();
      if (glitch && i == 4) begin
        sda_m = ~sda_m; @(negedge clk);
        sda_m = ~sda_m;
      end
      wait_q();
      scl_m = 1'b0; wait_q();
    end
  endtask

  task automatic ack_clock(output logic ack);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = ~sda_bus;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    send_bits(b, glitch);
    ack_clock(ack);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %0b expected 0", sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid: got %0b expected 0", wr_valid); end
    checks++; if (wr_addr !== 7'h00) begin failures++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    checks++; if (wr_data !== 9'h000) begin failures++; $display("FAIL reset_wr_data: got %h expected 000", wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rd_addr = 7'h19; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL reset_rd19: got %h expected 000", rd_data); end
  endtask

  task automatic test_write_basic();
    logic a0, a1, a2;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b expected 1", busy); end
    send_byte(8'h32, 1'b0, a1);
    send_byte(8'hFC, 1'b0, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL basic_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_stop: got %0b expected 0", busy); end
    checks++; if (n_wr !== 1) begin failures++; $display("FAIL basic_nwr: got %0d expected 1", n_wr); end
    checks++; if (last_addr !== 7'h19) begin failures++; $display("FAIL basic_addr: got %h expected 19", last_addr); end
    checks++; if (last_data !== 9'h0FC) begin failures++; $display("FAIL basic_data: got %h expected 0fc", last_data); end
    checks++; if (wr_data !== 9'h0FC) begin failures++; $display("FAIL basic_hold: got %h expected 0fc", wr_data); end
    rd_addr = 7'h19; #1;
    checks++; if (rd_data !== 9'h0FC) begin failures++; $display("FAIL basic_rd19: got %h expected 0fc", rd_data); end
  endtask

  task automatic test_bit8();
    logic a0, a1, a2;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0);
    send_byte(8'h35, 1'b0, a1);
    send_byte(8'hE1, 1'b0, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL bit8_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (n_wr !== 1 || last_addr !== 7'h1A || last_data !== 9'h1E1) begin
      failures++; $display("FAIL bit8_commit: got n=%0d a=%h d=%h expected n=1 a=1a d=1e1", n_wr, last_addr, last_data); end
    rd_addr = 7'h1A; #1;
    checks++; if (rd_data !== 9'h1E1) begin failures++; $display("FAIL bit8_rd1a: got %h expected 1e1", rd_data); end
  endtask

  task automatic test_bad_dev();
    logic a0, a1, a2, b0, b1, b2;
    n_wr = 0; oe_seen = 1'b0;
    bus_start();
    send_byte(8'h36, 1'b0, a0); send_byte(8'h32, 1'b0, a1); send_byte(8'h00, 1'b0, a2);
    bus_stop();
    bus_start();
    send_byte(8'h35, 1'b0, b0); send_byte(8'h34, 1'b0, b1); send_byte(8'h56, 1'b0, b2);
    bus_stop();
    checks++; if ({a0, a1, a2, b0, b1, b2} !== 6'b0) begin failures++; $display("FAIL baddev_acks: got %b expected 000000", {a0, a1, a2, b0, b1, b2}); end
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL baddev_oe: got %0b expected 0", oe_seen); end
    checks++; if (n_wr !== 0) begin failures++; $display("FAIL baddev_nwr: got %0d expected 0", n_wr); end
    rd_addr = 7'h19; #1;
    checks++; if (rd_data !== 9'h0FC) begin failures++; $display("FAIL baddev_rd19: got %h expected 0fc", rd_data); end
    rd_addr = 7'h1A; #1;
    checks++; if (rd_data !== 9'h1E1) begin failures++; $display("FAIL baddev_rd1a: got %h expected 1e1", rd_data); end
  endtask

  task automatic test_partial_swreset();
    logic a0, a1, a2;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0); send_byte(8'h32, 1'b0, a1);
    bus_stop();
    checks++; if (n_wr !== 0) begin failures++; $display("FAIL partial_nwr: got %0d expected 0", n_wr); end
    rd_addr = 7'h19; #1;
    checks++; if (rd_data !== 9'h0FC) begin failures++; $display("FAIL partial_rd19: got %h expected 0fc", rd_data); end
    bus_start();
    send_byte(8'h34, 1'b0, a0); send_byte(8'h1E, 1'b0, a1); send_byte(8'h00, 1'b0, a2);
    bus_stop();
    checks++; if (n_wr !== 1 || last_addr !== 7'h0F || last_data !== 9'h000) begin
      failures++; $display("FAIL swreset_commit: got n=%0d a=%h d=%h expected n=1 a=0f d=000", n_wr, last_addr, last_data); end
    rd_addr = 7'h19; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL swreset_rd19: got %h expected 000", rd_data); end
    rd_addr = 7'h1A; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL swreset_rd1a: got %h expected 000", rd_data); end
  endtask

  task automatic test_out_of_range();
    logic a0, a1, a2;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0); send_byte(8'h80, 1'b0, a1); send_byte(8'h55, 1'b0, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL oor_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (n_wr !== 1 || last_addr !== 7'h40 || last_data !== 9'h055) begin
      failures++; $display("FAIL oor_commit: got n=%0d a=%h d=%h expected n=1 a=40 d=055", n_wr, last_addr, last_data); end
    rd_addr = 7'h40; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL oor_rd40: got %h expected 000", rd_data); end
    rd_addr = 7'h00; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL oor_rd00: got %h expected 000", rd_data); end
    bus_start();
    send_byte(8'h34, 1'b0, a0); send_byte(8'h6E, 1'b0, a1); send_byte(8'h12, 1'b0, a2);
    bus_stop();
    rd_addr = 7'h37; #1;
    checks++; if (rd_data !== 9'h012) begin failures++; $display("FAIL last_reg_rd37: got %h expected 012", rd_data); end
  endtask

  task automatic test_wait_stop();
    logic a0, a1, a2, a3;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0); send_byte(8'h10, 1'b0, a1); send_byte(8'h0A, 1'b0, a2);
    send_byte(8'h77, 1'b0, a3);
    bus_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b1110) begin failures++; $display("FAIL waitstop_acks: got %b expected 1110", {a0, a1, a2, a3}); end
    checks++; if (n_wr !== 1) begin failures++; $display("FAIL waitstop_nwr: got %0d expected 1", n_wr); end
    rd_addr = 7'h08; #1;
    checks++; if (rd_data !== 9'h00A) begin failures++; $display("FAIL waitstop_rd08: got %h expected 00a", rd_data); end
  endtask

  task automatic test_back_to_back_rstart();
    logic a0, a1, a2, a3, a4;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0); send_byte(8'h04, 1'b0, a1);
    bus_rstart();
    send_byte(8'h34, 1'b0, a2); send_byte(8'h04, 1'b1, a3); send_byte(8'h05, 1'b0, a4);
    bus_stop();
    checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin failures++; $display("FAIL rstart_acks: got %b expected 11111", {a0, a1, a2, a3, a4}); end
    checks++; if (n_wr !== 1 || last_addr !== 7'h02 || last_data !== 9'h005) begin
      failures++; $display("FAIL rstart_commit: got n=%0d a=%h d=%h expected n=1 a=02 d=005", n_wr, last_addr, last_data); end
    rd_addr = 7'h02; #1;
    checks++; if (rd_data !== 9'h005) begin failures++; $display("FAIL rstart_rd02: got %h expected 005", rd_data); end
  endtask

  task automatic test_reset_mid_ack();
    logic a0;
    n_wr = 0;
    bus_start();
    send_byte(8'h34, 1'b0, a0);
    send_bits(8'h32, 1'b0);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL midack_oe_before: got %0b expected 1", sda_oe); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL midack_oe_after: got %0b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midack_busy: got %0b expected 0", busy); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
    checks++; if (n_wr !== 0) begin failures++; $display("FAIL midack_nwr: got %0d expected 0", n_wr); end
    rd_addr = 7'h02; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL midack_rd02: got %h expected 000", rd_data); end
    rd_addr = 7'h37; #1;
    checks++; if (rd_data !== 9'h000) begin failures++; $display("FAIL midack_rd37: got %h expected 000", rd_data); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_bit8();
    test_bad_dev();
    test_partial_swreset();
    test_out_of_range();
    test_wait_stop();
    test_back_to_back_rstart();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
